// File: rtl/frame_nibble_serializer_pkg.sv
// rtl/frame_nibble_serializer_pkg.sv - shared frame constants for the nibble serializer
package frame_nibble_serializer_pkg;

  localparam int             FRAME_LEN = 4;
  localparam logic [3:0]     PAD_FRAME = 4'b0000;

  // Detector patterns; PAD_FRAME must never equal one of these.
  localparam logic [3:0]     PAT_A     = 4'b1110;
  localparam logic [3:0]     PAT_B     = 4'b1001;
  localparam logic [3:0]     PAT_C     = 4'b0111;

endpackage

// File: rtl/frame_nibble_serializer_fifo.sv
// rtl/frame_nibble_serializer_fifo.sv - nibble_fifo, small sync FIFO with combinational head
module nibble_fifo
  import frame_nibble_serializer_pkg::*;
#(
  parameter int WIDTH = FRAME_LEN,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frame_nibble_serializer.sv
// rtl/frame_nibble_serializer.sv - buffers 4-bit frames and shifts them out MSB-first with PAD fill
module frame_nibble_serializer
  import frame_nibble_serializer_pkg::*;
#(
  parameter int                   DEPTH = 4,
  parameter logic [FRAME_LEN-1:0] PAD   = PAD_FRAME
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [FRAME_LEN-1:0] i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_out,
  output logic                 o_frame_start,
  output logic                 o_frame_real,
  output logic [7:0]           o_pad_cnt
);

  localparam int               CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]    LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0]        r_cnt;
  logic [FRAME_LEN-1:0] r_cur_frame;
  logic                 r_frame_real;
  logic [7:0]           r_pad_cnt;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_boundary;
  logic                 w_pop;
  logic [FRAME_LEN-1:0] w_head;

  assign w_boundary = (r_cnt == LAST);
  assign w_pop      = w_boundary && !w_empty;

  nibble_fifo #(
    .WIDTH (FRAME_LEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_in_valid),
    .i_pop   (w_pop),
    .i_din   (i_in_data),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Bit counter is never held, so frame boundaries stay locked to reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_cur_frame  <= PAD;
      r_frame_real <= 1'b0;
      r_pad_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      if (w_boundary) begin
        if (!w_empty) begin
          r_cur_frame  <= w_head;
          r_frame_real <= 1'b1;
        end else begin
          r_cur_frame  <= PAD;
          r_frame_real <= 1'b0;
          if (r_pad_cnt != 8'hFF) r_pad_cnt <= r_pad_cnt + 8'd1;
        end
      end
    end
  end

  assign o_out         = r_cur_frame[LAST - r_cnt];
  assign o_frame_start = (r_cnt == '0);
  assign o_frame_real  = r_frame_real;
  assign o_pad_cnt     = r_pad_cnt;
  assign o_in_ready    = !w_full;

endmodule
